// File: rtl/seq_buffer_if.sv
// Stream-load and dual read-port bundle for seq_buffer.
// The master side drives loads and reads. The slave side is the buffer itself.
interface seq_buffer_if #(
  parameter int unsigned W   = 9,
  parameter int unsigned BIT = 7
);
  logic           load_start;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_ready;
  logic           rd_en_a;
  logic [BIT-1:0] rd_addr_a;
  logic [W-1:0]   rd_data_a;
  logic           rd_en_b;
  logic [BIT-1:0] rd_addr_b;
  logic [W-1:0]   rd_data_b;
  logic [BIT:0]   seq_len;
  logic           loaded;
  logic           err_char;
  logic           err_ovf;

  modport master (
    output load_start, in_valid, in_data, in_last,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  in_ready, rd_data_a, rd_data_b, seq_len, loaded, err_char, err_ovf
  );

  modport slave (
    input  load_start, in_valid, in_data, in_last,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output in_ready, rd_data_a, rd_data_b, seq_len, loaded, err_char, err_ovf
  );
endinterface

// File: rtl/seq_buffer.sv
// Sequence store for the NW aligner: streams in one DNA sequence, validates it,
// and serves two independent registered read ports that pad to zero past the length.
module seq_buffer #(
  parameter int unsigned N         = 128,
  parameter int unsigned W         = 9,
  parameter int unsigned BIT       = $clog2(N),
  parameter bit          CHK_ALPHA = 1'b1
) (
  input logic         clk,
  input logic         rst,
  seq_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_mem [N];
  logic [BIT-1:0] r_ptr;
  logic [BIT:0]   r_len;
  logic           r_err_char;
  logic           r_err_ovf;
  logic [W-1:0]   r_rd_a;
  logic [W-1:0]   r_rd_b;

  logic           w_ready;
  logic           w_accept;
  logic           w_legal;
  logic           w_write;
  logic           w_full_next;
  logic           w_set_char;
  logic           w_set_ovf;

  assign w_ready  = (r_state == LOAD);
  // load_start wins over a beat presented in the same cycle.
  assign w_accept = bus.in_valid && w_ready && !bus.load_start;

  always_comb begin
    w_legal = 1'b1;
    if (CHK_ALPHA) begin
      case (bus.in_data[7:0])
        8'h41, 8'h43, 8'h47, 8'h54: w_legal = 1'b1;
        default:                    w_legal = 1'b0;
      endcase
    end
  end

  assign w_write     = w_accept && w_legal;
  assign w_full_next = (r_len == (BIT+1)'(N - 1));
  assign w_set_char  = w_accept && !w_legal;
  assign w_set_ovf   = w_write && w_full_next && !bus.in_last;

  always_comb begin
    w_next = r_state;
    if (bus.load_start) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_set_char)
            w_next = ERR;
          else if (w_write && (bus.in_last || w_full_next))
            w_next = DONE;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_len      <= '0;
      r_err_char <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else if (bus.load_start) begin
      r_ptr      <= '0;
      r_len      <= '0;
      r_err_char <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_write) begin
        r_ptr <= r_ptr + BIT'(1);
        r_len <= r_len + (BIT+1)'(1);
      end
      if (w_set_char) r_err_char <= 1'b1;
      if (w_set_ovf)  r_err_ovf  <= 1'b1;
    end
  end

  // Storage is not reset, so it is kept in a block with no reset branch.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_ptr] <= bus.in_data;
  end

  // Reads see the pre-write memory and the pre-update length of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      if (bus.rd_en_a)
        r_rd_a <= ({1'b0, bus.rd_addr_a} < r_len) ? r_mem[bus.rd_addr_a] : '0;
      if (bus.rd_en_b)
        r_rd_b <= ({1'b0, bus.rd_addr_b} < r_len) ? r_mem[bus.rd_addr_b] : '0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.rd_data_a = r_rd_a;
  assign bus.rd_data_b = r_rd_b;
  assign bus.seq_len   = r_len;
  assign bus.loaded    = (r_state == DONE);
  assign bus.err_char  = r_err_char;
  assign bus.err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_seq_buffer.sv
// Directed bench for seq_buffer with N=8: a vector table for single-cycle behaviour,
// followed by hand-written sequences for gapped loads, reload and mid-load reset.
module tb_seq_buffer;

  localparam int unsigned N = 8;
  localparam int unsigned W = 9;
  localparam int unsigned B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_buffer_if #(.W(W), .BIT(B)) bus ();

  seq_buffer #(.N(N), .W(W), .BIT(B), .CHK_ALPHA(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         ld;
    logic         v;
    logic [W-1:0] d;
    logic         last;
    logic         ea;
    logic [B-1:0] aa;
    logic         eb;
    logic [B-1:0] ab;
    logic         rdy;
    logic [B:0]   len;
    logic         ldd;
    logic         ec;
    logic         eo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic ld, input logic v, input logic [W-1:0] d, input logic last,
    input logic ea, input logic [B-1:0] aa, input logic eb, input logic [B-1:0] ab,
    input logic rdy, input logic [B:0] len, input logic ldd, input logic ec,
    input logic eo, input logic [W-1:0] ra, input logic [W-1:0] rb);
    vec_t r;
    r.ld = ld; r.v = v; r.d = d; r.last = last;
    r.ea = ea; r.aa = aa; r.eb = eb; r.ab = ab;
    r.rdy = rdy; r.len = len; r.ldd = ldd; r.ec = ec; r.eo = eo;
    r.ra = ra; r.rb = rb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic v, input logic [W-1:0] d, input logic last);
    bus.load_start = ld;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_last    = last;
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic [B:0] len,
                            input logic ldd, input logic ec, input logic eo);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    chk({tag, ".seq_len"},  32'(bus.seq_len),  32'(len));
    chk({tag, ".loaded"},   32'(bus.loaded),   32'(ldd));
    chk({tag, ".err_char"}, 32'(bus.err_char), 32'(ec));
    chk({tag, ".err_ovf"},  32'(bus.err_ovf),  32'(eo));
  endtask

  logic [W-1:0] s6 [6];
  logic [W-1:0] s3 [3];
  int idx;
  int cyc;
  logic v;

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0);
    bus.rd_en_a = 1'b0; bus.rd_addr_a = '0;
    bus.rd_en_b = 1'b0; bus.rd_addr_b = '0;

    // Reset values
    tick(); tick();
    chk_status("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.rd_data_a", 32'(bus.rd_data_a), 32'h0);
    chk("reset.rd_data_b", 32'(bus.rd_data_b), 32'h0);
    rst = 1'b0;
    tick();

    //          ld v  data    lst ea aa   eb ab   rdy len   ldd ec eo ra      rb
    // basic load C,T,G,A,T and reads
    vt.push_back(mk(1, 0, 9'h00, 0, 0, 3'd0, 0, 3'd0, 1, 4'd0, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h43, 0, 0, 3'd0, 0, 3'd0, 1, 4'd1, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h54, 0, 0, 3'd0, 0, 3'd0, 1, 4'd2, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h47, 0, 0, 3'd0, 0, 3'd0, 1, 4'd3, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h41, 0, 0, 3'd0, 0, 3'd0, 1, 4'd4, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h54, 1, 0, 3'd0, 0, 3'd0, 0, 4'd5, 1, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 0, 9'h00, 0, 1, 3'd2, 1, 3'd4, 0, 4'd5, 1, 0, 0, 9'h47, 9'h54));
    // pad past seq_len, then hold with enables low
    vt.push_back(mk(0, 0, 9'h00, 0, 1, 3'd7, 1, 3'd7, 0, 4'd5, 1, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 0, 9'h00, 0, 1, 3'd0, 1, 3'd1, 0, 4'd5, 1, 0, 0, 9'h43, 9'h54));
    vt.push_back(mk(0, 0, 9'h00, 0, 0, 3'd2, 0, 3'd4, 0, 4'd5, 1, 0, 0, 9'h43, 9'h54));
    vt.push_back(mk(0, 0, 9'h00, 0, 1, 3'd7, 1, 3'd7, 0, 4'd5, 1, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 0, 9'h00, 0, 0, 3'd0, 0, 3'd0, 0, 4'd5, 1, 0, 0, 9'h00, 9'h00));
    // illegal character A,C,N,G
    vt.push_back(mk(1, 0, 9'h00, 0, 0, 3'd0, 0, 3'd0, 1, 4'd0, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h41, 0, 0, 3'd0, 0, 3'd0, 1, 4'd1, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h43, 0, 0, 3'd0, 0, 3'd0, 1, 4'd2, 0, 0, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h4E, 0, 0, 3'd0, 0, 3'd0, 0, 4'd2, 0, 1, 0, 9'h00, 9'h00));
    vt.push_back(mk(0, 1, 9'h47, 0, 1, 3'd1, 1, 3'd2, 0, 4'd2, 0, 1, 0, 9'h43, 9'h00));
    vt.push_back(mk(1, 0, 9'h00, 0, 0, 3'd0, 0, 3'd0, 1, 4'd0, 0, 0, 0, 9'h43, 9'h00));
    // overflow: 8 legal chars, no last
    vt.push_back(mk(0, 1, 9'h41, 0, 0, 3'd0, 0, 3'd0, 1, 4'd1, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h43, 0, 0, 3'd0, 0, 3'd0, 1, 4'd2, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h47, 0, 0, 3'd0, 0, 3'd0, 1, 4'd3, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h54, 0, 0, 3'd0, 0, 3'd0, 1, 4'd4, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h41, 0, 0, 3'd0, 0, 3'd0, 1, 4'd5, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h43, 0, 0, 3'd0, 0, 3'd0, 1, 4'd6, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h47, 0, 0, 3'd0, 0, 3'd0, 1, 4'd7, 0, 0, 0, 9'h43, 9'h00));
    vt.push_back(mk(0, 1, 9'h54, 0, 0, 3'd0, 0, 3'd0, 0, 4'd8, 1, 0, 1, 9'h43, 9'h00));
    vt.push_back(mk(0, 0, 9'h00, 0, 1, 3'd7, 1, 3'd0, 0, 4'd8, 1, 0, 1, 9'h54, 9'h41));
    // load_start drops a same-cycle beat; then 8 chars with last on the 8th
    vt.push_back(mk(1, 1, 9'h41, 0, 0, 3'd0, 0, 3'd0, 1, 4'd0, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h54, 0, 0, 3'd0, 0, 3'd0, 1, 4'd1, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h47, 0, 0, 3'd0, 0, 3'd0, 1, 4'd2, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h43, 0, 0, 3'd0, 0, 3'd0, 1, 4'd3, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h41, 0, 0, 3'd0, 0, 3'd0, 1, 4'd4, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h54, 0, 0, 3'd0, 0, 3'd0, 1, 4'd5, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h47, 0, 0, 3'd0, 0, 3'd0, 1, 4'd6, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h43, 0, 0, 3'd0, 0, 3'd0, 1, 4'd7, 0, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 1, 9'h41, 1, 0, 3'd0, 0, 3'd0, 0, 4'd8, 1, 0, 0, 9'h54, 9'h41));
    vt.push_back(mk(0, 0, 9'h00, 0, 1, 3'd7, 1, 3'd1, 0, 4'd8, 1, 0, 0, 9'h41, 9'h47));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ld, vt[i].v, vt[i].d, vt[i].last);
      bus.rd_en_a = vt[i].ea; bus.rd_addr_a = vt[i].aa;
      bus.rd_en_b = vt[i].eb; bus.rd_addr_b = vt[i].ab;
      tick();
      chk_status($sformatf("vec%0d", i), vt[i].rdy, vt[i].len, vt[i].ldd, vt[i].ec, vt[i].eo);
      chk($sformatf("vec%0d.rd_data_a", i), 32'(bus.rd_data_a), 32'(vt[i].ra));
      chk($sformatf("vec%0d.rd_data_b", i), 32'(bus.rd_data_b), 32'(vt[i].rb));
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;

    // Gapped 6-char load with random in_valid
    s6[0] = 9'h43; s6[1] = 9'h41; s6[2] = 9'h54;
    s6[3] = 9'h47; s6[4] = 9'h47; s6[5] = 9'h41;
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      drive(1'b0, v, s6[idx], idx == 5);
      tick();
      if (v) idx++;
      cyc++;
      chk("gap.seq_len", 32'(bus.seq_len), 32'(idx));
    end
    chk("gap.bound", 32'(idx), 32'd6);
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    chk_status("gap.done", 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 6; a++) begin
      bus.rd_en_a = 1'b1; bus.rd_addr_a = B'(a);
      bus.rd_en_b = 1'b1; bus.rd_addr_b = B'(5 - a);
      tick();
      chk($sformatf("gap.mem_a%0d", a), 32'(bus.rd_data_a), 32'(s6[a]));
      chk($sformatf("gap.mem_b%0d", 5 - a), 32'(bus.rd_data_b), 32'(s6[5 - a]));
    end
    bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;

    // Reload from DONE with a shorter sequence; stale tail must read as pad
    s3[0] = 9'h47; s3[1] = 9'h43; s3[2] = 9'h54;
    drive(1'b1, 1'b0, '0, 1'b0);
    tick();
    chk_status("reload.start", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, s3[k], k == 2);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    chk_status("reload.done", 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 3'd4;
    bus.rd_en_b = 1'b1; bus.rd_addr_b = 3'd2;
    tick();
    chk("reload.pad_a4", 32'(bus.rd_data_a), 32'h0);
    chk("reload.rd_b2", 32'(bus.rd_data_b), 32'h54);
    bus.rd_en_b = 1'b0;

    // Asynchronous reset in the middle of a load
    drive(1'b1, 1'b0, '0, 1'b0);
    bus.rd_addr_a = 3'd0;
    tick();
    drive(1'b0, 1'b1, 9'h41, 1'b0); tick();
    drive(1'b0, 1'b1, 9'h43, 1'b0); tick();
    drive(1'b0, 1'b1, 9'h47, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    bus.rd_en_a = 1'b0;
    chk("midrst.pre_len", 32'(bus.seq_len), 32'd3);
    chk("midrst.pre_rd_a", 32'(bus.rd_data_a), 32'h41);
    #2 rst = 1'b1;
    #1;
    chk_status("midrst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("midrst.rd_data_a", 32'(bus.rd_data_a), 32'h0);
    chk("midrst.rd_data_b", 32'(bus.rd_data_b), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0); tick();
    drive(1'b0, 1'b1, 9'h54, 1'b0); tick();
    drive(1'b0, 1'b1, 9'h41, 1'b1); tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk_status("postrst", 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 3'd1;
    tick();
    chk("postrst.rd_a1", 32'(bus.rd_data_a), 32'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
